pipe_mux_reg: RTL and testbench

//  Parametrised N-input, W-bit select-and-register stage for the pipelined MIPS datapath.
//  - Used for forwarding, ALU-source and writeback selection.
//  - Keeps the gated-enable semantics of the 2:1 datapath mux: disabled selects 0.
//  - Adds a DEPTH-stage pipeline with valid tracking, stall, flush and a bad-select flag.
//  - Sits between the forwarding/control unit and the next pipeline register.

---
 rtl/mips_mux_pkg.sv | 8 +
 rtl/pipe_stage_reg.sv | 16 +
 rtl/pipe_mux_reg.sv | 68 ++++++
 tb/tb_pipe_mux_reg.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mips_mux_pkg.sv
// mips_mux_pkg: shared limits and select-width helper for the pipelined datapath muxes.
package mips_mux_pkg;
   localparam int MUX_MAX_IN    = 16;
   localparam int MUX_MAX_DEPTH = 4;
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register; reset beats flush, flush beats stall.
module pipe_stage_reg #(
   parameter type stage_t = logic
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   stall,
   input  logic   flush,
   input  stage_t d,
   output stage_t q
);
   always_ff @(posedge clk)
      if (!rst_n) q <= '0;
      else if (flush) q <= '0;
      else if (!stall) q <= d;
endmodule

// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: gated N:1 select followed by a DEPTH-stage valid/err-tracking pipeline.
module pipe_mux_reg
   import mips_mux_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = sel_width(NUM_IN),
   parameter int DEPTH  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    stall,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    sel_err
);
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             valid;
      logic             err;
   } stage_t;
   // one extra bit so NUM_IN == 2**SEL_W compares correctly
   localparam logic [SEL_W:0] N_L = (SEL_W + 1)'(NUM_IN);
   logic [WIDTH-1:0] pick;
   logic             bad;
   stage_t           stage_d [DEPTH];
   stage_t           stage_q [DEPTH];
   if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_chk_n
      $error("pipe_mux_reg: NUM_IN out of range");
   end
   if (DEPTH < 1 || DEPTH > MUX_MAX_DEPTH) begin : g_chk_d
      $error("pipe_mux_reg: DEPTH out of range");
   end
   if (SEL_W != sel_width(NUM_IN)) begin : g_chk_s
      $error("pipe_mux_reg: SEL_W must not be overridden");
   end
   always_comb begin
      pick = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (en && sel == SEL_W'(k)) pick = in_data[k*WIDTH +: WIDTH];
   end
   assign bad        = en && in_valid && ({1'b0, sel} >= N_L);
   assign stage_d[0] = in_valid ? {pick, 1'b1, bad} : '0;
   genvar i;
   for (i = 0; i < DEPTH; i++) begin : g_stage
      if (i > 0) begin : g_link
         assign stage_d[i] = stage_q[i-1];
      end
      pipe_stage_reg #(.stage_t(stage_t)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .stall (stall),
         .flush (flush),
         .d     (stage_d[i]),
         .q     (stage_q[i])
      );
   end
   assign in_ready  = ~stall;
   assign out_data  = stage_q[DEPTH-1].data;
   assign out_valid = stage_q[DEPTH-1].valid;
   assign sel_err   = stage_q[DEPTH-1].err;
endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb_pipe_mux_reg: directed checks of a 4-input and a 3-input instance, both DEPTH=2.
module tb_pipe_mux_reg;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [63:0] in_data = 64'h4444_3333_2222_1111;
   logic [1:0]  sel = 0;
   logic        en = 1, in_valid = 0, stall = 0, flush = 0;
   logic        rdy4, rdy3, ov4, ov3, er4, er3;
   logic [15:0] od4, od3;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   pipe_mux_reg #(.WIDTH(16), .NUM_IN(4), .DEPTH(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .en(en),
      .in_valid(in_valid), .in_ready(rdy4), .stall(stall), .flush(flush),
      .out_data(od4), .out_valid(ov4), .sel_err(er4));

   pipe_mux_reg #(.WIDTH(16), .NUM_IN(3), .DEPTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[47:0]), .sel(sel), .en(en),
      .in_valid(in_valid), .in_ready(rdy3), .stall(stall), .flush(flush),
      .out_data(od3), .out_valid(ov3), .sel_err(er3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out4(input string tag, input logic [15:0] d, input logic v, input logic e);
      chk({tag, ".data"}, {16'h0, od4}, {16'h0, d});
      chk({tag, ".valid"}, {31'h0, ov4}, {31'h0, v});
      chk({tag, ".err"}, {31'h0, er4}, {31'h0, e});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset, with stall and flush also high to show reset wins
      stall = 1; flush = 1; in_valid = 1;
      step(); step();
      out4("rst", 16'h0, 0, 0);
      chk("rst3.valid", {31'h0, ov3}, 0);
      rst_n = 1; stall = 0; flush = 0; in_valid = 0;
      step();
      // 1: single pulse sel=2
      sel = 2; en = 1; in_valid = 1;
      step();
      in_valid = 0;
      out4("t1.lat1", 16'h0, 0, 0);
      step();
      out4("t1.out", 16'h3333, 1, 0);
      chk("t1.dut3", {16'h0, od3}, 32'h3333);
      step();
      out4("t1.gone", 16'h0, 0, 0);
      // 2: en=0 gives a valid zero entry, no error
      sel = 1; en = 0; in_valid = 1;
      step();
      in_valid = 0; en = 1;
      step();
      out4("t2.out", 16'h0, 1, 0);
      step();
      // 3: sel=3 is out of range only for the 3-input instance
      sel = 3; in_valid = 1;
      step();
      in_valid = 0;
      step();
      chk("t3.d3", {16'h0, od3}, 0);
      chk("t3.v3", {31'h0, ov3}, 1);
      chk("t3.e3", {31'h0, er3}, 1);
      out4("t3.d4", 16'h4444, 1, 0);
      step();
      chk("t3.e3clr", {31'h0, er3}, 0);
      chk("t3.v3clr", {31'h0, ov3}, 0);
      // 4: stream 0..3 with a 3-cycle stall
      sel = 0; in_valid = 1;
      step();
      sel = 1;
      step();
      out4("t4.o0", 16'h1111, 1, 0);
      sel = 2; stall = 1;
      #1;
      chk("t4.ready", {31'h0, rdy4}, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         out4($sformatf("t4.hold%0d", c), 16'h1111, 1, 0);
      end
      stall = 0;
      #1;
      chk("t4.ready1", {31'h0, rdy4}, 1);
      step();
      out4("t4.o1", 16'h2222, 1, 0);
      sel = 3;
      step();
      out4("t4.o2", 16'h3333, 1, 0);
      in_valid = 0;
      step();
      out4("t4.o3", 16'h4444, 1, 0);
      step();
      out4("t4.end", 16'h0, 0, 0);
      // 5: flush with stall high kills in-flight and incoming entries
      sel = 0; in_valid = 1;
      step();
      sel = 1;
      step();
      out4("t5.pre", 16'h1111, 1, 0);
      sel = 2; flush = 1; stall = 1;
      step();
      out4("t5.flush", 16'h0, 0, 0);
      flush = 0; stall = 0; in_valid = 0;
      step();
      out4("t5.after1", 16'h0, 0, 0);
      step();
      out4("t5.after2", 16'h0, 0, 0);
      // 6: mid-stream reset while full
      sel = 0; in_valid = 1;
      step();
      sel = 1;
      step();
      rst_n = 0; sel = 2;
      step();
      out4("t6.rst", 16'h0, 0, 0);
      rst_n = 1; sel = 3;
      step();
      in_valid = 0;
      out4("t6.lat1", 16'h0, 0, 0);
      step();
      out4("t6.out", 16'h4444, 1, 0);
      step();
      out4("t6.end", 16'h0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
